twiddle_addr_gen: RTL and testbench
===================================

Name: twiddle_addr_gen

Overview:
Parametrised twiddle-index generator for one stage of a radix-2 SDF FFT pipeline. It sits beside each stage's butterfly and drives the twiddle ROM address plus a bypass flag to that stage's complex multiplier. NFFT, stage number and the forward/inverse direction are configurable. It supports stalled input (valid gaps), back-to-back frames, a synchronous abort, and frame-boundary flags.

Parameters:
NFFT, 64, transform size; power of two, 4..1024
LOG2N, 6, log2(NFFT); also the address width
STAGE_NO, 1, stage index, 1..LOG2N; stage 1 is the first SDF stage

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
in_valid  input  1  a sample enters the stage this cycle
inverse  input  1  1 = IFFT (conjugate twiddles); sampled only at frame start
clear  input  1  synchronous abort; returns the block to IDLE
tw_addr  output  LOG2N  twiddle ROM index k, where W = W_NFFT^k
tw_valid  output  1  tw_addr/tw_bypass are valid this cycle
tw_bypass  output  1  twiddle is trivial (k=0); the multiplier may pass data through
frame_first  output  1  output corresponds to sample 0 of a frame
frame_last  output  1  output corresponds to sample NFFT-1 of a frame
busy  output  1  a frame is in progress (state RUN)

Behaviour:
- Reset (rst low, async): state IDLE, sample counter 0, latched direction 0. All outputs 0.
- All outputs are registered. Latency is 1 cycle from an in_valid sample to its tw_valid.
- Local constants:
  - M = NFFT >> (STAGE_NO-1) (butterfly span).
  - H = M/2.
  - SH = STAGE_NO-1.
- Per accepted sample with frame counter c (0..NFFT-1), let n = c mod M (the low LOG2N-SH bits of c):
  - if n < H: kf = 0, bypass = 1
  - else: kf = (n - H) << SH, bypass = (kf == 0)
  - kf always lies in 0..NFFT/2-1.
  - Forward mode: tw_addr = kf.
  - Inverse mode: tw_addr = (NFFT - kf) mod NFFT, i.e. 0 stays 0; computed in LOG2N bits with natural wrap.
- State machine (2 states):
  - IDLE:
    - in_valid=1 accepts sample 0, latches `inverse`, and moves to RUN with c <= 1.
    - frame_first is asserted with that output.
  - RUN:
    - Each in_valid=1 accepts sample c and increments c. in_valid=0 holds c and drives tw_valid=0 next cycle (stall).
    - On acceptance of c = NFFT-1: frame_last=1, c wraps to 0, state goes to IDLE.
    - A sample arriving the very next cycle starts a new frame through IDLE with no bubble. Back-to-back frames therefore produce continuous tw_valid.
- The `inverse` input is ignored mid-frame; a direction change takes effect only at the next frame_first.
- clear=1 has priority over in_valid in the same cycle:
  - next cycle: c=0, IDLE, all outputs 0.
  - A sample presented with clear is dropped.
- Asserting rst mid-frame behaves as clear, but immediately (asynchronously).
- tw_addr, tw_bypass, frame_first and frame_last are 0 whenever tw_valid=0.
- busy = (state == RUN), registered with the state.
- Legacy equivalence: NFFT=64, STAGE_NO=1, forward mode reproduces the existing stage-1 index sequence at the sample positions.

Decomposition:
- Shared package (fft_pkg): NFFT, LOG2N, the ST_IDLE/ST_RUN state encodings, and a constant function clog2 used to derive address widths for all stages.
- One natural sub-module: tw_index_calc. It is purely combinational, maps (c, inverse) -> (k, bypass) for a given STAGE_NO, and is reused by the ROM-size checks in other stages.
- Counter, FSM and output registers stay in twiddle_addr_gen.

Test Plan:
1. NFFT=64, STAGE_NO=1, forward, 64 consecutive valids -> samples 0..31: addr 0, bypass=1; samples 32..63: addr 0..31; bypass=1 only at sample 32; frame_first at sample 0, frame_last at sample 63.
2. STAGE_NO=2, forward -> samples 0..15: bypass; sample 16->0, 17->2, 31->30; the pattern repeats from sample 32 (48->0, 63->30).
3. STAGE_NO=1, inverse=1 at frame start -> sample 33 gives addr 63, sample 63 gives addr 33, sample 32 gives addr 0. Toggling inverse mid-frame produces no change until the next frame.
4. Stall: valid pattern 1,0,0,1 at c=40 -> tw_valid 1,0,0,1; the addresses are 8 then 9; the counter does not advance during the gaps.
5. Back-to-back: two frames with in_valid held high for 128 cycles -> tw_valid continuous, frame_last at cycles 64 and 128, frame_first at cycles 1 and 65.
6. Abort: clear at c=20, then rst low at c=50 of the next frame -> outputs go to 0 and busy=0; the next valid restarts at sample 0 with frame_first=1.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared constants and helpers for the radix-2 SDF FFT pipeline.
// Stage modules import this for sizing and FSM encodings.
package fft_pkg;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    localparam int NFFT  = 64;
    localparam int LOG2N = clog2(NFFT);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/tw_index_calc.sv
// Combinational twiddle index for one SDF stage.
// Maps frame position and direction to ROM index and bypass flag.
module tw_index_calc #(
    parameter int NFFT     = 64,
    parameter int LOG2N    = 6,
    parameter int STAGE_NO = 1
) (
    input  logic [LOG2N-1:0] c,
    input  logic             inv,
    output logic [LOG2N-1:0] k,
    output logic             bypass
);

    localparam int SH = STAGE_NO - 1;
    localparam int M  = NFFT >> SH;
    localparam int H  = M / 2;

    localparam logic [LOG2N-1:0] MASK = LOG2N'(M - 1);
    localparam logic [LOG2N-1:0] HALF = LOG2N'(H);

    logic [LOG2N-1:0] n;
    logic [LOG2N-1:0] kf;

    always_comb begin
        n = c & MASK;
        if (n < HALF) begin
            kf = '0;
        end else begin
            kf = (n - HALF) << SH;
        end
        bypass = (kf == '0);
        // Conjugate twiddle: NFFT - kf wraps naturally in LOG2N bits
        k = inv ? (LOG2N'(0) - kf) : kf;
    end

endmodule

// File: rtl/twiddle_addr_gen.sv
// Twiddle ROM address generator for one radix-2 SDF stage.
// Frame counter, two-state FSM and registered outputs.
module twiddle_addr_gen #(
    parameter int NFFT     = fft_pkg::NFFT,
    parameter int LOG2N    = fft_pkg::clog2(NFFT),
    parameter int STAGE_NO = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             inverse,
    input  logic             clear,
    output logic [LOG2N-1:0] tw_addr,
    output logic             tw_valid,
    output logic             tw_bypass,
    output logic             frame_first,
    output logic             frame_last,
    output logic             busy
);

    import fft_pkg::*;

    localparam logic [LOG2N-1:0] C_LAST = LOG2N'(NFFT - 1);

    state_t           state_q, state_d;
    logic [LOG2N-1:0] cnt_q, cnt_d;
    logic             inv_q, inv_d;

    logic [LOG2N-1:0] c_eff;
    logic             inv_eff;
    logic [LOG2N-1:0] k;
    logic             byp;

    logic [LOG2N-1:0] addr_q, addr_d;
    logic             vld_q, vld_d;
    logic             byp_q, byp_d;
    logic             first_q, first_d;
    logic             last_q, last_d;
    logic             busy_q, busy_d;

    tw_index_calc #(
        .NFFT     (NFFT),
        .LOG2N    (LOG2N),
        .STAGE_NO (STAGE_NO)
    ) u_calc (
        .c      (c_eff),
        .inv    (inv_eff),
        .k      (k),
        .bypass (byp)
    );

    always_comb begin
        // In IDLE the incoming sample is sample 0 with the live direction
        c_eff   = (state_q == ST_RUN) ? cnt_q : '0;
        inv_eff = (state_q == ST_RUN) ? inv_q : inverse;

        state_d = state_q;
        cnt_d   = cnt_q;
        inv_d   = inv_q;
        vld_d   = 1'b0;
        addr_d  = '0;
        byp_d   = 1'b0;
        first_d = 1'b0;
        last_d  = 1'b0;

        if (clear) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            inv_d   = 1'b0;
        end else if (in_valid) begin
            vld_d   = 1'b1;
            addr_d  = k;
            byp_d   = byp;
            first_d = (state_q == ST_IDLE);
            last_d  = (c_eff == C_LAST);
            inv_d   = inv_eff;
            if (c_eff == C_LAST) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end else begin
                state_d = ST_RUN;
                cnt_d   = c_eff + LOG2N'(1);
            end
        end

        busy_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            inv_q   <= 1'b0;
            addr_q  <= '0;
            vld_q   <= 1'b0;
            byp_q   <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            inv_q   <= inv_d;
            addr_q  <= addr_d;
            vld_q   <= vld_d;
            byp_q   <= byp_d;
            first_q <= first_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
        end
    end

    assign tw_addr     = addr_q;
    assign tw_valid    = vld_q;
    assign tw_bypass   = byp_q;
    assign frame_first = first_q;
    assign frame_last  = last_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_twiddle_addr_gen.sv
// Directed bench for twiddle_addr_gen, stages 1 and 2 side by side.
module tb_twiddle_addr_gen;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       inverse;
    logic       clear;

    logic [5:0] a_addr, b_addr;
    logic       a_vld, a_byp, a_first, a_last, a_busy;
    logic       b_vld, b_byp, b_first, b_last, b_busy;

    int n_chk;
    int n_fail;

    twiddle_addr_gen #(.NFFT(64), .LOG2N(6), .STAGE_NO(1)) u_s1 (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .inverse     (inverse),
        .clear       (clear),
        .tw_addr     (a_addr),
        .tw_valid    (a_vld),
        .tw_bypass   (a_byp),
        .frame_first (a_first),
        .frame_last  (a_last),
        .busy        (a_busy)
    );

    twiddle_addr_gen #(.NFFT(64), .LOG2N(6), .STAGE_NO(2)) u_s2 (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .inverse     (inverse),
        .clear       (clear),
        .tw_addr     (b_addr),
        .tw_valid    (b_vld),
        .tw_bypass   (b_byp),
        .frame_first (b_first),
        .frame_last  (b_last),
        .busy        (b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Expected index for a 64-point stage with shift sh
    function automatic int ref_k(input int c, input int sh, input bit inv);
        int m, h, n, k;
        m = 64 >> sh;
        h = m / 2;
        n = c % m;
        k = (n < h) ? 0 : ((n - h) << sh);
        return inv ? ((64 - k) % 64) : k;
    endfunction

    function automatic int ref_byp(input int c, input int sh);
        return (ref_k(c, sh, 1'b0) == 0) ? 1 : 0;
    endfunction

    task automatic step(input bit v, input bit inv, input bit clr);
        @(negedge clk);
        in_valid = v;
        inverse  = inv;
        clear    = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_a_vld"}, a_vld, 0);
        check({tag, "_a_addr"}, a_addr, 0);
        check({tag, "_a_byp"}, a_byp, 0);
        check({tag, "_a_first"}, a_first, 0);
        check({tag, "_a_last"}, a_last, 0);
        check({tag, "_b_vld"}, b_vld, 0);
        check({tag, "_b_addr"}, b_addr, 0);
    endtask

    task automatic feed(input int c0, input int n, input bit inv_drv,
                        input bit inv_exp);
        int c;
        for (int i = 0; i < n; i++) begin
            c = c0 + i;
            step(1'b1, inv_drv, 1'b0);
            check($sformatf("c%0d_a_vld", c), a_vld, 1);
            check($sformatf("c%0d_a_addr", c), a_addr, ref_k(c, 0, inv_exp));
            check($sformatf("c%0d_a_byp", c), a_byp, ref_byp(c, 0));
            check($sformatf("c%0d_a_first", c), a_first, c == 0);
            check($sformatf("c%0d_a_last", c), a_last, c == 63);
            check($sformatf("c%0d_a_busy", c), a_busy, c != 63);
            check($sformatf("c%0d_b_vld", c), b_vld, 1);
            check($sformatf("c%0d_b_addr", c), b_addr, ref_k(c, 1, inv_exp));
            check($sformatf("c%0d_b_byp", c), b_byp, ref_byp(c, 1));
            check($sformatf("c%0d_b_first", c), b_first, c == 0);
            check($sformatf("c%0d_b_last", c), b_last, c == 63);
        end
    endtask

    initial begin
        n_chk    = 0;
        n_fail   = 0;
        rst      = 1'b0;
        in_valid = 1'b0;
        inverse  = 1'b0;
        clear    = 1'b0;
        #12;
        check_idle("reset");
        check("reset_a_busy", a_busy, 0);
        check("reset_b_busy", b_busy, 0);
        rst = 1'b1;

        // Forward frame with hand-picked anchor points
        feed(0, 32, 1'b0, 1'b0);
        check("fwd_c31_a_addr", a_addr, 0);
        check("fwd_c31_b_addr", b_addr, 30);
        feed(32, 1, 1'b0, 1'b0);
        check("fwd_c32_a_addr", a_addr, 0);
        check("fwd_c32_a_byp", a_byp, 1);
        check("fwd_c32_b_byp", b_byp, 1);
        feed(33, 1, 1'b0, 1'b0);
        check("fwd_c33_a_addr", a_addr, 1);
        check("fwd_c33_a_byp", a_byp, 0);
        feed(34, 30, 1'b0, 1'b0);
        check("fwd_c63_a_addr", a_addr, 31);
        check("fwd_c63_b_addr", b_addr, 30);
        check("fwd_c63_last", a_last, 1);
        step(1'b0, 1'b0, 1'b0);
        check_idle("gap1");
        check("gap1_busy", a_busy, 0);

        // Inverse frame, input toggled back to forward mid-frame
        feed(0, 10, 1'b1, 1'b1);
        feed(10, 22, 1'b0, 1'b1);
        feed(32, 1, 1'b0, 1'b1);
        check("inv_c32_a_addr", a_addr, 0);
        feed(33, 1, 1'b0, 1'b1);
        check("inv_c33_a_addr", a_addr, 63);
        feed(34, 30, 1'b1, 1'b1);
        check("inv_c63_a_addr", a_addr, 33);
        step(1'b0, 1'b0, 1'b0);
        check_idle("gap2");

        // Stall at c=40: valid 1,0,0,1
        feed(0, 40, 1'b0, 1'b0);
        feed(40, 1, 1'b0, 1'b0);
        check("stall_c40_addr", a_addr, 8);
        step(1'b0, 1'b0, 1'b0);
        check_idle("stall_g1");
        check("stall_g1_busy", a_busy, 1);
        step(1'b0, 1'b1, 1'b0);
        check_idle("stall_g2");
        check("stall_g2_busy", a_busy, 1);
        feed(41, 1, 1'b0, 1'b0);
        check("stall_c41_addr", a_addr, 9);
        feed(42, 22, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check_idle("gap3");

        // Two back-to-back frames, valid held high for 128 cycles
        feed(0, 64, 1'b0, 1'b0);
        feed(0, 64, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check_idle("gap4");

        // Clear at c=20 with a sample presented
        feed(0, 20, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        check_idle("clear");
        check("clear_a_busy", a_busy, 0);
        check("clear_b_busy", b_busy, 0);
        feed(0, 50, 1'b0, 1'b0);

        // Asynchronous reset at c=50
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b0;
        #1;
        check_idle("arst");
        check("arst_a_busy", a_busy, 0);
        check("arst_b_busy", b_busy, 0);
        #2;
        rst = 1'b1;
        feed(0, 1, 1'b0, 1'b0);
        check("restart_first", a_first, 1);
        check("restart_busy", a_busy, 1);
        feed(1, 33, 1'b0, 1'b0);
        check("restart_c33_addr", a_addr, 1);
        step(1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
